// File: rtl/if_stage_unit.sv
// rtl/if_stage_unit.sv - RV32IM instruction fetch stage with IF/ID pipeline register
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_bubbles counters.
module if_stage_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] drain_target;
  logic [31:0] target;
  logic        accept;
  logic        load_valid;
  logic        load_bubble;

  assign imem_addr = pc;
  assign imem_read = reset_n && (state != ST_HOLD);
  assign accept    = imem_read && !imem_busywait;
  assign target    = redirect_pc & 32'hFFFF_FFFC;

  // IF/ID update classification; redirects win over stall and accept
  assign load_valid  = !redirect_valid && !stall &&
                       (((state == ST_REQ) && accept) || (state == ST_HOLD));
  assign load_bubble = (redirect_valid && (state != ST_DRAIN)) ||
                       (!redirect_valid && !stall && (state == ST_REQ) && imem_busywait);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      buf_pc       <= 32'h0;
      buf_instr    <= 32'h0;
      drain_target <= 32'h0;
      if_id_pc     <= 32'h0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
    end else begin
      if (load_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= (state == ST_HOLD) ? buf_pc : pc;
        if_id_instr <= (state == ST_HOLD) ? buf_instr : imem_rdata;
      end else if (load_bubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end

      case (state)
        ST_REQ: begin
          if (redirect_valid) begin
            // A busy access cannot be abandoned, so park the target until it completes
            if (imem_busywait) begin
              drain_target <= target;
              state        <= ST_DRAIN;
            end else begin
              pc <= target;
            end
          end else if (accept) begin
            if (stall) begin
              buf_pc    <= pc;
              buf_instr <= imem_rdata;
              state     <= ST_HOLD;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= ST_REQ;
          end else if (!stall) begin
            pc    <= pc + 32'd4;
            state <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (redirect_valid) drain_target <= target;
          if (accept) begin
            pc    <= redirect_valid ? target : drain_target;
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else begin
      if (load_valid)  perf_fetched <= perf_fetched + 32'd1;
      if (load_bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
